// File: rtl/fft_frame_scheduler.sv
// Frame sequencer for the spectrum path: capture N samples, stream them to the FFT,
// keep the lower N/2 bins, and copy them to VRAM only while the display is in vertical blank.
module fft_frame_scheduler #(
  parameter int unsigned WORD_SIZE      = 16,
  parameter int unsigned FRAME_LOG2     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                  inClock,
  input  logic                  reset,
  input  logic                  sampleValid,
  input  logic [WORD_SIZE-1:0]  sampleData,
  output logic                  fftStart,
  output logic                  fftInValid,
  output logic [FRAME_LOG2-1:0] fftInIndex,
  output logic [WORD_SIZE-1:0]  fftInData,
  input  logic                  fftOutValid,
  input  logic [FRAME_LOG2-1:0] fftOutIndex,
  input  logic [WORD_SIZE-1:0]  fftOutData,
  input  logic                  fftDone,
  input  logic                  vBlank,
  input  logic                  freeze,
  output logic                  vramWriteEnable,
  output logic [FRAME_LOG2-2:0] vramWriteAddr,
  output logic [WORD_SIZE-1:0]  vramWriteData,
  output logic                  busy,
  output logic [15:0]           frameCount,
  output logic [7:0]            errorCount
);

  localparam int unsigned N     = 1 << FRAME_LOG2;
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_CAPTURE,
    S_LOAD,
    S_WAIT_FFT,
    S_WAIT_VBLANK,
    S_COMMIT
  } state_e;

  state_e                state_q, state_d;
  logic [FRAME_LOG2-1:0] ptr_q, ptr_d;
  logic [FRAME_LOG2-2:0] commit_q, commit_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;

  logic                  start_q, start_d;
  logic                  in_valid_q, in_valid_d;
  logic [FRAME_LOG2-1:0] in_index_q, in_index_d;
  logic [WORD_SIZE-1:0]  in_data_q, in_data_d;
  logic                  we_q, we_d;
  logic [FRAME_LOG2-2:0] waddr_q, waddr_d;
  logic [WORD_SIZE-1:0]  wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic [15:0]           frame_q, frame_d;
  logic [7:0]            err_q, err_d;

  logic                  sample_we_c;
  logic                  result_we_c;

  logic [WORD_SIZE-1:0]  sample_mem [N];
  logic [WORD_SIZE-1:0]  result_mem [HALF];

  // Storage RAMs; intentionally not reset, every location is rewritten before use.
  always_ff @(posedge inClock) begin
    if (sample_we_c) begin
      sample_mem[ptr_q] <= sampleData;
    end
    if (result_we_c) begin
      result_mem[fftOutIndex[FRAME_LOG2-2:0]] <= fftOutData;
    end
  end

  always_ff @(posedge inClock or posedge reset) begin
    if (reset) begin
      state_q    <= S_CAPTURE;
      ptr_q      <= '0;
      commit_q   <= '0;
      tmo_q      <= '0;
      start_q    <= 1'b0;
      in_valid_q <= 1'b0;
      in_index_q <= '0;
      in_data_q  <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      busy_q     <= 1'b0;
      frame_q    <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      commit_q   <= commit_d;
      tmo_q      <= tmo_d;
      start_q    <= start_d;
      in_valid_q <= in_valid_d;
      in_index_q <= in_index_d;
      in_data_q  <= in_data_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      frame_q    <= frame_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    commit_d    = commit_q;
    tmo_d       = tmo_q;
    start_d     = 1'b0;
    in_valid_d  = 1'b0;
    in_index_d  = in_index_q;
    in_data_d   = in_data_q;
    we_d        = 1'b0;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    frame_d     = frame_q;
    err_d       = err_q;
    sample_we_c = 1'b0;
    result_we_c = 1'b0;

    case (state_q)
      S_CAPTURE: begin
        if (sampleValid) begin
          sample_we_c = 1'b1;
          ptr_d       = ptr_q + FRAME_LOG2'(1);
          if (ptr_q == '1) begin
            state_d = S_LOAD;
          end
        end
      end
      // ptr wraps back to 0 after the last word, ready for the next capture.
      S_LOAD: begin
        in_valid_d = 1'b1;
        start_d    = (ptr_q == '0);
        in_index_d = ptr_q;
        in_data_d  = sample_mem[ptr_q];
        ptr_d      = ptr_q + FRAME_LOG2'(1);
        if (ptr_q == '1) begin
          state_d = S_WAIT_FFT;
          tmo_d   = '0;
        end
      end
      S_WAIT_FFT: begin
        result_we_c = fftOutValid && !fftOutIndex[FRAME_LOG2-1];
        if (fftDone) begin
          state_d = freeze ? S_CAPTURE : S_WAIT_VBLANK;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_CAPTURE;
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_WAIT_VBLANK: begin
        if (vBlank) begin
          state_d  = S_COMMIT;
          commit_d = '0;
        end
      end
      S_COMMIT: begin
        we_d     = 1'b1;
        waddr_d  = commit_q;
        wdata_d  = result_mem[commit_q];
        commit_d = commit_q + (FRAME_LOG2 - 1)'(1);
        if (commit_q == '1) begin
          frame_d = frame_q + 16'd1;
          state_d = S_CAPTURE;
        end
      end
      default: begin
        state_d = S_CAPTURE;
      end
    endcase

    busy_d = (state_d != S_CAPTURE);
  end

  assign fftStart        = start_q;
  assign fftInValid      = in_valid_q;
  assign fftInIndex      = in_index_q;
  assign fftInData       = in_data_q;
  assign vramWriteEnable = we_q;
  assign vramWriteAddr   = waddr_q;
  assign vramWriteData   = wdata_q;
  assign busy            = busy_q;
  assign frameCount      = frame_q;
  assign errorCount      = err_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Scoreboard bench for fft_frame_scheduler with N=16 and a 20-cycle FFT timeout.
module tb_fft_frame_scheduler;

  logic        clk;
  logic        rst;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        fft_start;
  logic        fft_in_valid;
  logic [3:0]  fft_in_index;
  logic [15:0] fft_in_data;
  logic        fft_out_valid;
  logic [3:0]  fft_out_index;
  logic [15:0] fft_out_data;
  logic        fft_done;
  logic        vblank;
  logic        freeze;
  logic        vram_we;
  logic [2:0]  vram_addr;
  logic [15:0] vram_data;
  logic        busy;
  logic [15:0] frame_count;
  logic [7:0]  error_count;

  int checks;
  int failures;
  int fft_seen;
  int vram_seen;
  logic [20:0] fft_q [$];
  logic [18:0] vram_q [$];
  logic [20:0] fexp;
  logic [18:0] vexp;

  fft_frame_scheduler #(
    .WORD_SIZE(16),
    .FRAME_LOG2(4),
    .TIMEOUT_CYCLES(20)
  ) dut (
    .inClock(clk),
    .reset(rst),
    .sampleValid(sample_valid),
    .sampleData(sample_data),
    .fftStart(fft_start),
    .fftInValid(fft_in_valid),
    .fftInIndex(fft_in_index),
    .fftInData(fft_in_data),
    .fftOutValid(fft_out_valid),
    .fftOutIndex(fft_out_index),
    .fftOutData(fft_out_data),
    .fftDone(fft_done),
    .vBlank(vblank),
    .freeze(freeze),
    .vramWriteEnable(vram_we),
    .vramWriteAddr(vram_addr),
    .vramWriteData(vram_data),
    .busy(busy),
    .frameCount(frame_count),
    .errorCount(error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a word.
  always @(negedge clk) begin
    if (fft_in_valid) begin
      fft_seen++;
      if (fft_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL fft_in_unexpected actual=0x%0h expected=none", {fft_start, fft_in_index, fft_in_data});
      end else begin
        fexp = fft_q.pop_front();
        check("fft_in", 32'({fft_start, fft_in_index, fft_in_data}), 32'(fexp));
      end
    end else if (fft_start) begin
      check("fft_start_without_valid", 32'(fft_start), 32'(0));
    end
    if (vram_we) begin
      vram_seen++;
      if (vram_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL vram_unexpected actual=0x%0h expected=none", {vram_addr, vram_data});
      end else begin
        vexp = vram_q.pop_front();
        check("vram_write", 32'({vram_addr, vram_data}), 32'(vexp));
      end
    end
  end

  // Feeds one frame; returns positioned 16 negedges after the last sample was driven.
  task automatic feed_frame(input int base, input bit drop);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      sample_valid = 1'b1;
      sample_data  = 16'(base + i);
      fft_q.push_back({(i == 0), 4'(i), 16'(base + i)});
    end
    @(negedge clk);
    sample_valid = 1'b0;
    check("load_gap", 32'(fft_in_valid), 32'(0));
    @(negedge clk);
    check("load_latency", 32'({fft_in_valid, fft_start}), 32'(2'b11));
    for (int k = 3; k <= 16; k++) begin
      @(negedge clk);
      if (drop && k <= 10 && (k % 2 == 1)) begin
        sample_valid = 1'b1;
        sample_data  = 16'h7FFF;
      end else begin
        sample_valid = 1'b0;
      end
    end
  endtask

  task automatic fft_reply(input int bin_base, input int push_n, input bit frz);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      fft_out_valid = 1'b1;
      fft_out_index = 4'(i);
      fft_out_data  = 16'(bin_base + i);
      if (i < push_n) vram_q.push_back({3'(i), 16'(bin_base + i)});
    end
    @(negedge clk);
    fft_out_valid = 1'b0;
    fft_done      = 1'b1;
    freeze        = frz;
    @(negedge clk);
    fft_done = 1'b0;
    freeze   = 1'b0;
    check("busy_after_done", 32'(busy), 32'(!frz));
  endtask

  task automatic commit_frame(input int exp_frames);
    int seen0;
    seen0 = vram_seen;
    repeat (50) @(negedge clk);
    check("no_write_before_vblank", 32'(vram_seen), 32'(seen0));
    check("busy_waiting_vblank", 32'(busy), 32'(1));
    vblank = 1'b1;
    @(negedge clk);
    check("commit_gap", 32'(vram_we), 32'(0));
    @(negedge clk);
    check("commit_latency", 32'(vram_we), 32'(1));
    @(negedge clk);
    vblank = 1'b0;
    repeat (8) @(negedge clk);
    check("frame_count", 32'(frame_count), 32'(exp_frames));
    check("busy_after_commit", 32'(busy), 32'(0));
    check("vram_queue_empty", 32'(vram_q.size()), 32'(0));
  endtask

  initial begin
    int seen0;
    checks        = 0;
    failures      = 0;
    fft_seen      = 0;
    vram_seen     = 0;
    rst           = 1'b1;
    sample_valid  = 1'b0;
    sample_data   = '0;
    fft_out_valid = 1'b0;
    fft_out_index = '0;
    fft_out_data  = '0;
    fft_done      = 1'b0;
    vblank        = 1'b0;
    freeze        = 1'b0;

    // Reset with random inputs
    repeat (6) begin
      @(negedge clk);
      sample_valid  = 1'($urandom);
      sample_data   = 16'($urandom);
      fft_out_valid = 1'($urandom);
      fft_out_index = 4'($urandom);
      fft_out_data  = 16'($urandom);
      fft_done      = 1'($urandom);
      vblank        = 1'($urandom);
      freeze        = 1'($urandom);
    end
    check("reset_outputs", 32'({fft_start, fft_in_valid, fft_in_index, fft_in_data, vram_we, vram_addr}), 32'(0));
    check("reset_vram_data", 32'(vram_data), 32'(0));
    check("reset_busy", 32'(busy), 32'(0));
    check("reset_counts", 32'({frame_count, error_count}), 32'(0));
    sample_valid  = 1'b0;
    fft_out_valid = 1'b0;
    fft_done      = 1'b0;
    vblank        = 1'b0;
    freeze        = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Freeze discards the spectrum
    feed_frame(20, 1'b0);
    fft_reply(500, 0, 1'b1);
    repeat (5) @(negedge clk);
    check("freeze_no_writes", 32'(vram_seen), 32'(0));
    check("freeze_frame_count", 32'(frame_count), 32'(0));

    // Full frame with commit during vblank
    feed_frame(0, 1'b0);
    fft_reply(100, 8, 1'b0);
    commit_frame(1);

    // Timeouts with dropped samples, saturating error count
    seen0 = vram_seen;
    for (int it = 0; it < 300; it++) begin
      feed_frame(16 * (it % 50) + 3, 1'b1);
      for (int k = 17; k <= 37; k++) begin
        @(negedge clk);
        sample_valid = (k <= 30) && (k % 2 == 1);
        sample_data  = 16'h7FFF;
        if (k == 36 && it == 0) check("busy_before_timeout", 32'(busy), 32'(1));
      end
      if (it == 0) begin
        check("busy_after_timeout", 32'(busy), 32'(0));
        check("error_count_first", 32'(error_count), 32'(1));
      end
    end
    check("error_count_saturated", 32'(error_count), 32'(255));
    check("timeout_no_writes", 32'(vram_seen), 32'(seen0));
    check("timeout_frame_count", 32'(frame_count), 32'(1));

    // Reset in the middle of a commit
    feed_frame(40, 1'b0);
    fft_reply(200, 3, 1'b0);
    repeat (10) @(negedge clk);
    vblank = 1'b1;
    repeat (4) @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_mid_commit_we", 32'(vram_we), 32'(0));
    check("reset_mid_commit_frames", 32'(frame_count), 32'(0));
    check("reset_mid_commit_busy", 32'(busy), 32'(0));
    vblank = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Next frame commits normally
    feed_frame(70, 1'b0);
    fft_reply(300, 8, 1'b0);
    commit_frame(1);

    check("fft_queue_empty", 32'(fft_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
